// File: rtl/multdiv_iter_if.sv
// EXE-stage handshake bundle for the iterative multiply/divide unit.
// The pipeline side drives the operands, start and flush; the unit drives stall, done and HI/LO.
interface multdiv_iter_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] hi_i;
    logic [WIDTH-1:0] lo_i;
    logic             flush_i;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, hi_i, lo_i, flush_i,
        input  stall_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, hi_i, lo_i, flush_i,
        output stall_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/multdiv_iter.sv
// Iterative MULT/DIV/MADD/MSUB unit: shift-add multiply (MUL_STEP bits per cycle),
// restoring divide (one bit per cycle), sign fix-up and accumulate in FIX, done pulse in DONE.
module multdiv_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 4
) (
    input logic           clk,
    input logic           rst,
    multdiv_iter_if.slave bus
);
    localparam int N  = WIDTH / MUL_STEP;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]      MUL_LAST = CW'(N - 1);
    localparam logic [CW-1:0]      DIV_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
    localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? neg_w(x) : x;
    endfunction

    state_t             state_r, nxt_s, state_s;
    logic [2:0]         op_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   a_raw_r;
    logic [2*WIDTH-1:0] opnd_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] hl_r;
    logic               neg_lo_r, neg_hi_r, div0_r;
    logic [WIDTH-1:0]   hi_r, lo_r;

    logic               accept_s, div_op_s, b_zero_s, a_neg_s, b_neg_s;
    logic [2*WIDTH-1:0] pp_s, div_nxt_s, prod_s, sum_s;
    logic [WIDTH:0]     shl_s, diff_s;
    logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;

    assign accept_s = (state_r == IDLE) && bus.start_i && !bus.flush_i;
    assign div_op_s = (bus.op_i[2:1] == 2'b01);
    assign b_zero_s = (bus.b_i == ZERO_W);
    assign a_neg_s  = !bus.op_i[0] && bus.a_i[WIDTH-1];
    assign b_neg_s  = !bus.op_i[0] && bus.b_i[WIDTH-1];

    // Next-state decode; flush overrides every transition
    always_comb begin
        nxt_s = state_r;
        case (state_r)
            IDLE:    nxt_s = !accept_s ? IDLE : (!div_op_s ? MUL : (b_zero_s ? FIX : DIV));
            MUL:     nxt_s = (cnt_r == MUL_LAST) ? FIX : MUL;
            DIV:     nxt_s = (cnt_r == DIV_LAST) ? FIX : DIV;
            FIX:     nxt_s = DONE;
            DONE:    nxt_s = IDLE;
            default: nxt_s = IDLE;
        endcase
        state_s = bus.flush_i ? IDLE : nxt_s;
    end

    // One multiply digit and one restoring-division bit; acc holds {remainder, dividend/quotient} in DIV
    always_comb begin
        pp_s   = opnd_r * {{(2*WIDTH-MUL_STEP){1'b0}}, mplier_r[MUL_STEP-1:0]};
        shl_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        diff_s = shl_s - {1'b0, opnd_r[WIDTH-1:0]};
        if (diff_s[WIDTH]) begin
            div_nxt_s = {shl_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end else begin
            div_nxt_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction, accumulate and divide-by-zero result
    always_comb begin
        prod_s = neg_lo_r ? neg_2w(acc_r) : acc_r;
        sum_s  = prod_s;
        case (op_r)
            3'd4, 3'd5: sum_s = hl_r + prod_s;
            3'd6, 3'd7: sum_s = hl_r - prod_s;
            default:    sum_s = prod_s;
        endcase
        if (div0_r) begin
            fix_hi_s = a_raw_r;
            fix_lo_s = ONES_W;
        end else if (op_r[2:1] == 2'b01) begin
            fix_hi_s = mag(acc_r[2*WIDTH-1:WIDTH], neg_hi_r);
            fix_lo_s = mag(acc_r[WIDTH-1:0], neg_lo_r);
        end else begin
            fix_hi_s = sum_s[2*WIDTH-1:WIDTH];
            fix_lo_s = sum_s[WIDTH-1:0];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= 3'd0;
            cnt_r    <= CNT_ZERO;
            a_raw_r  <= ZERO_W;
            opnd_r   <= ZERO_2W;
            mplier_r <= ZERO_W;
            acc_r    <= ZERO_2W;
            hl_r     <= ZERO_2W;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            div0_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r     <= bus.op_i;
                        cnt_r    <= CNT_ZERO;
                        a_raw_r  <= bus.a_i;
                        hl_r     <= {bus.hi_i, bus.lo_i};
                        neg_lo_r <= a_neg_s ^ b_neg_s;
                        neg_hi_r <= a_neg_s;
                        div0_r   <= div_op_s && b_zero_s;
                        if (div_op_s) begin
                            acc_r    <= {ZERO_W, mag(bus.a_i, a_neg_s)};
                            opnd_r   <= {ZERO_W, mag(bus.b_i, b_neg_s)};
                            mplier_r <= ZERO_W;
                        end else begin
                            acc_r    <= ZERO_2W;
                            opnd_r   <= {ZERO_W, mag(bus.a_i, a_neg_s)};
                            mplier_r <= mag(bus.b_i, b_neg_s);
                        end
                    end
                end
                MUL: begin
                    acc_r    <= acc_r + pp_s;
                    opnd_r   <= opnd_r << MUL_STEP;
                    mplier_r <= mplier_r >> MUL_STEP;
                    cnt_r    <= cnt_r + CNT_ONE;
                end
                DIV: begin
                    acc_r <= div_nxt_s;
                    cnt_r <= cnt_r + CNT_ONE;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Result registers: only an unflushed FIX commits a new HI/LO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r <= ZERO_W;
            lo_r <= ZERO_W;
        end else if ((state_r == FIX) && !bus.flush_i) begin
            hi_r <= fix_hi_s;
            lo_r <= fix_lo_s;
        end
    end

    assign bus.stall_o = accept_s || (state_r == MUL) || (state_r == DIV) || (state_r == FIX);
    assign bus.done_o  = (state_r == DONE);
    assign bus.hi_o    = hi_r;
    assign bus.lo_o    = lo_r;
endmodule

// File: tb/tb_multdiv_iter.sv
// Randomised and directed bench for multdiv_iter at WIDTH=32/MUL_STEP=4 and WIDTH=16/MUL_STEP=2,
// checked against a plain-arithmetic model of the HI/LO results and cycle counts.
module tb_multdiv_iter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multdiv_iter_if #(.WIDTH(32)) m32 ();
    multdiv_iter_if #(.WIDTH(16)) m16 ();

    multdiv_iter #(.WIDTH(32), .MUL_STEP(4)) dut32 (.clk(clk), .rst(rst), .bus(m32.slave));
    multdiv_iter #(.WIDTH(16), .MUL_STEP(2)) dut16 (.clk(clk), .rst(rst), .bus(m16.slave));

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, h, l, eh, el;
        int          cyc;
    } vec_t;

    // Reference: {hi, lo} of width w from integer arithmetic modulo 2^(2w)
    function automatic logic [63:0] model(input int w, input logic [2:0] op,
                                          input logic [31:0] a, b, h, l);
        logic [63:0] m1, m2, ua, ub, hl, p, r, qv, rv, t;
        longint      sa, sb, q, rm;
        m1 = (64'd1 << w) - 64'd1;
        m2 = (64'd1 << (2 * w)) - 64'd1;
        ua = {32'd0, a} & m1;
        ub = {32'd0, b} & m1;
        sa = longint'(ua << (64 - w)) >>> (64 - w);
        sb = longint'(ub << (64 - w)) >>> (64 - w);
        hl = ((({32'd0, h} & m1) << w) | ({32'd0, l} & m1));
        p  = 64'd0;
        if (op == 3'd2 || op == 3'd3) begin
            if (ub == 64'd0) begin
                r = (ua << w) | m1;
            end else begin
                if (op == 3'd2) begin
                    q  = sa / sb;
                    rm = sa % sb;
                    qv = q;
                    rv = rm;
                end else begin
                    qv = ua / ub;
                    rv = ua % ub;
                end
                r = ((rv & m1) << w) | (qv & m1);
            end
        end else begin
            if (op[0]) begin
                p = ua * ub;
            end else begin
                q = sa * sb;
                p = q;
            end
            if (op == 3'd4 || op == 3'd5)      r = hl + p;
            else if (op == 3'd6 || op == 3'd7) r = hl - p;
            else                               r = p;
        end
        r = r & m2;
        t = r >> w;
        r = r & m1;
        return {t[31:0], r[31:0]};
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        case ($urandom_range(5, 0))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return m;
            3:       return 32'd1 << (w - 1);
            default: return $urandom & m;
        endcase
    endfunction

    task automatic drive(input bit w16, input bit st, input logic [2:0] op,
                         input logic [31:0] a, b, h, l);
        if (w16) begin
            m16.start_i = st; m16.op_i = op; m16.a_i = a[15:0]; m16.b_i = b[15:0];
            m16.hi_i = h[15:0]; m16.lo_i = l[15:0];
        end else begin
            m32.start_i = st; m32.op_i = op; m32.a_i = a; m32.b_i = b;
            m32.hi_i = h; m32.lo_i = l;
        end
    endtask

    // Starts an op in the current cycle (cycle 0) and waits, bounded, for done_o
    task automatic do_op(input bit w16, input logic [2:0] op, input logic [31:0] a, b, h, l,
                         output logic [31:0] ho, lo, output int dcyc,
                         output bit stall0, output bit stall_bad);
        bit st, dn;
        drive(w16, 1'b1, op, a, b, h, l);
        #1;
        stall0    = w16 ? m16.stall_o : m32.stall_o;
        dcyc      = -1;
        stall_bad = 1'b0;
        ho        = 32'd0;
        lo        = 32'd0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                if (w16) m16.start_i = 1'b0; else m32.start_i = 1'b0;
            end
            #1;
            st = w16 ? m16.stall_o : m32.stall_o;
            dn = w16 ? m16.done_o : m32.done_o;
            if (dn) begin
                dcyc = c;
                ho   = w16 ? {16'd0, m16.hi_o} : m32.hi_o;
                lo   = w16 ? {16'd0, m16.lo_o} : m32.lo_o;
                if (st) stall_bad = 1'b1;
                break;
            end else if (!st) begin
                stall_bad = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        m32.flush_i = 1'b0;
        m16.flush_i = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++; if (m32.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", m32.stall_o); end
        checks++; if (m32.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", m32.done_o); end
        checks++; if (m32.hi_o !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", m32.hi_o); end
        checks++; if (m32.lo_o !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", m32.lo_o); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_table32(input string tag, input vec_t v[7]);
        logic [31:0] ho, lo;
        int          dc;
        bit          s0, sb;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            checks++; if (m32.done_o !== 1'b0) begin errors++; $display("FAIL %s_done_pulse vec %0d got %b want 0", tag, i, m32.done_o); end
            do_op(1'b0, v[i].op, v[i].a, v[i].b, v[i].h, v[i].l, ho, lo, dc, s0, sb);
            checks++; if (dc !== v[i].cyc) begin errors++; $display("FAIL %s_cycle vec %0d got %0d want %0d", tag, i, dc, v[i].cyc); end
            checks++; if (ho !== v[i].eh) begin errors++; $display("FAIL %s_hi vec %0d got %h want %h", tag, i, ho, v[i].eh); end
            checks++; if (lo !== v[i].el) begin errors++; $display("FAIL %s_lo vec %0d got %h want %h", tag, i, lo, v[i].el); end
            checks++; if (s0 !== 1'b1 || sb !== 1'b0) begin errors++; $display("FAIL %s_stall vec %0d got c0=%b bad=%b want c0=1 bad=0", tag, i, s0, sb); end
        end
    endtask

    task automatic test_mult();
        vec_t v[7];
        v[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,        32'd0, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 10};
        v[1] = '{3'd1, 32'd3,         32'd4,        32'd0, 32'd0,        32'd0,         32'd12,        10};
        v[2] = '{3'd5, 32'd1,         32'd1,        32'd0, 32'hFFFF_FFFF, 32'd1,        32'd0,         10};
        v[3] = '{3'd6, 32'd1,         32'd1,        32'd0, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 10};
        v[4] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,       32'hFFFF_FFFE, 32'd1,         10};
        v[5] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0,       32'h4000_0000, 32'd0,         10};
        v[6] = '{3'd4, 32'hFFFF_FFFF, 32'd2,        32'd0, 32'd5,        32'd0,         32'd3,         10};
        run_table32("mult", v);
    endtask

    task automatic test_div();
        vec_t v[7];
        v[0] = '{3'd3, 32'd100,       32'd7,         32'd0, 32'd0, 32'd2,         32'd14,        34};
        v[1] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
        v[2] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0,         32'h8000_0000, 34};
        v[3] = '{3'd3, 32'd5,         32'd0,         32'd0, 32'd0, 32'd5,         32'hFFFF_FFFF, 2};
        v[4] = '{3'd2, 32'hFFFF_FFF9, 32'd0,         32'd0, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 2};
        v[5] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd0, 32'd0, 32'd1,         32'hFFFF_FFFD, 34};
        v[6] = '{3'd3, 32'hFFFF_FFFF, 32'd1,         32'd0, 32'd0, 32'd0,         32'hFFFF_FFFF, 34};
        run_table32("div", v);
    endtask

    task automatic test_flush();
        logic [31:0] ho, lo;
        int          dc;
        bit          s0, sb, seen;
        @(posedge clk); #1;
        do_op(1'b0, 3'd1, 32'd3, 32'd4, 32'd0, 32'd0, ho, lo, dc, s0, sb);
        checks++; if (lo !== 32'd12 || ho !== 32'd0) begin errors++; $display("FAIL flush_pre got %h_%h want 0_c", ho, lo); end
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'd2, 32'd1000, 32'd3, 32'd0, 32'd0);
        seen = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            m32.start_i = 1'b0;
            if (c == 5) m32.flush_i = 1'b1;
            #1;
            if (m32.done_o) seen = 1'b1;
        end
        checks++; if (m32.stall_o !== 1'b1) begin errors++; $display("FAIL flush_cycle5_stall got %b want 1", m32.stall_o); end
        @(posedge clk); #1;
        m32.flush_i = 1'b0;
        #1;
        checks++; if (m32.stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", m32.stall_o); end
        checks++; if (m32.done_o !== 1'b0 || seen) begin errors++; $display("FAIL flush_done got %b seen %b want 0", m32.done_o, seen); end
        checks++; if (m32.hi_o !== 32'd0 || m32.lo_o !== 32'd12) begin errors++; $display("FAIL flush_keep got %h_%h want 0_c", m32.hi_o, m32.lo_o); end
        do_op(1'b0, 3'd1, 32'd5, 32'd6, 32'd0, 32'd0, ho, lo, dc, s0, sb);
        checks++; if (dc !== 10 || lo !== 32'd30 || ho !== 32'd0) begin errors++; $display("FAIL flush_after got cyc %0d %h_%h want 10 0_1e", dc, ho, lo); end
    endtask

    task automatic test_flush_start();
        int n_done, n_stall;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'd0, 32'd5, 32'd5, 32'd0, 32'd0);
        m32.flush_i = 1'b1;
        #1;
        checks++; if (m32.stall_o !== 1'b0) begin errors++; $display("FAIL flush_start_stall got %b want 0", m32.stall_o); end
        @(posedge clk); #1;
        m32.start_i = 1'b0;
        m32.flush_i = 1'b0;
        n_done = 0; n_stall = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (m32.done_o) n_done++;
            if (m32.stall_o) n_stall++;
            @(posedge clk); #1;
        end
        checks++; if (n_done !== 0 || n_stall !== 0) begin errors++; $display("FAIL flush_start_idle got done %0d stall %0d want 0 0", n_done, n_stall); end
        checks++; if (m32.lo_o !== 32'd30) begin errors++; $display("FAIL flush_start_keep got %h want 1e", m32.lo_o); end
    endtask

    task automatic test_flush_fix();
        logic [31:0] ho, lo;
        int          dc, n_done;
        bit          s0, sb;
        @(posedge clk); #1;
        do_op(1'b0, 3'd1, 32'd2, 32'd5, 32'd0, 32'd0, ho, lo, dc, s0, sb);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'd1, 32'd7, 32'd9, 32'd0, 32'd0);
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            m32.start_i = 1'b0;
            if (c == 9) m32.flush_i = 1'b1;
        end
        @(posedge clk); #1;
        m32.flush_i = 1'b0;
        #1;
        n_done = m32.done_o ? 1 : 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #2;
            if (m32.done_o) n_done++;
        end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL flush_fix_done got %0d want 0", n_done); end
        checks++; if (m32.lo_o !== 32'd10 || m32.hi_o !== 32'd0) begin errors++; $display("FAIL flush_fix_keep got %h_%h want 0_a", m32.hi_o, m32.lo_o); end
    endtask

    task automatic test_random32();
        logic [31:0] a, b, h, l, ho, lo;
        logic [63:0] e;
        logic [2:0]  op;
        int          dc, ec;
        bit          s0, sb;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(7, 0));
            a = pick(32); b = pick(32); h = $urandom; l = $urandom;
            e  = model(32, op, a, b, h, l);
            ec = (op == 3'd2 || op == 3'd3) ? ((b == 32'd0) ? 2 : 34) : 10;
            @(posedge clk); #1;
            checks++; if (m32.done_o !== 1'b0) begin errors++; $display("FAIL rnd_done_pulse it %0d got %b want 0", i, m32.done_o); end
            do_op(1'b0, op, a, b, h, l, ho, lo, dc, s0, sb);
            checks++;
            if (dc !== ec || {ho, lo} !== e || s0 !== 1'b1 || sb !== 1'b0) begin
                errors++;
                $display("FAIL rnd32 op %0d a %h b %h h %h l %h got cyc %0d %h_%h stall %b%b want cyc %0d %h_%h stall 10",
                         op, a, b, h, l, dc, ho, lo, s0, sb, ec, e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [31:0] ho, lo;
        int          dc, n_done;
        bit          s0, sb;
        @(posedge clk); #1;
        do_op(1'b0, 3'd0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, ho, lo, dc, s0, sb);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'd3, 32'd1000, 32'd3, 32'd0, 32'd0);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            m32.start_i = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (m32.stall_o !== 1'b0 || m32.done_o !== 1'b0 || m32.hi_o !== 32'd0 || m32.lo_o !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid got stall %b done %b %h_%h want 0 0 0_0", m32.stall_o, m32.done_o, m32.hi_o, m32.lo_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #2;
            if (m32.done_o) n_done++;
        end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL rst_mid_done got %0d want 0", n_done); end
    endtask

    task automatic test_w16();
        logic [31:0] a, b, h, l, ho, lo;
        logic [63:0] e;
        logic [2:0]  op;
        int          dc, ec;
        bit          s0, sb;
        @(posedge clk); #1;
        do_op(1'b1, 3'd1, 32'h0000_FFFF, 32'h0000_FFFF, 32'd0, 32'd0, ho, lo, dc, s0, sb);
        checks++; if (dc !== 10) begin errors++; $display("FAIL w16_cycle got %0d want 10", dc); end
        checks++; if (ho !== 32'h0000_FFFE || lo !== 32'h0000_0001) begin errors++; $display("FAIL w16_mulu got %h_%h want fffe_0001", ho, lo); end
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(7, 0));
            a = pick(16); b = pick(16); h = $urandom & 32'hFFFF; l = $urandom & 32'hFFFF;
            e  = model(16, op, a, b, h, l);
            ec = (op == 3'd2 || op == 3'd3) ? ((b == 32'd0) ? 2 : 18) : 10;
            @(posedge clk); #1;
            do_op(1'b1, op, a, b, h, l, ho, lo, dc, s0, sb);
            checks++;
            if (dc !== ec || {ho, lo} !== e || s0 !== 1'b1 || sb !== 1'b0) begin
                errors++;
                $display("FAIL rnd16 op %0d a %h b %h h %h l %h got cyc %0d %h_%h stall %b%b want cyc %0d %h_%h stall 10",
                         op, a, b, h, l, dc, ho, lo, s0, sb, ec, e[63:32], e[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_flush();
        test_flush_start();
        test_flush_fix();
        test_random32();
        test_rst_mid();
        test_w16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multdiv_iter.md
# multdiv_iter

Parametrised iterative multiply/divide unit for the EXE stage. It executes MULT/MULTU/DIV/DIVU and the accumulate forms MADD/MADDU/MSUB/MSUBU over a configurable operand width, with a configurable number of multiplier bits retired per cycle. It drives the EXE-stage stall, produces registered HI/LO results with a one-cycle done pulse, and cancels cleanly on pipeline flush.

## Interface
- WIDTH, 32: operand width; HI/LO are each WIDTH bits; must be even and >= 8.
- MUL_STEP, 4: multiplier bits retired per cycle; must divide WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start_i  in  1  EXE holds a mult/div instruction; sampled only in IDLE.
- op_i  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- a_i  in  WIDTH  rs operand (dividend / multiplicand), already forwarded.
- b_i  in  WIDTH  rt operand (divisor / multiplier), already forwarded.
- hi_i  in  WIDTH  current HI (forwarded), used by ops 4-7.
- lo_i  in  WIDTH  current LO (forwarded), used by ops 4-7.
- flush_i  in  1  exception/flush; aborts any operation in progress.
- stall_o  out  1  freeze IF..EXE while asserted.
- done_o  out  1  one-cycle pulse; hi_o/lo_o are valid.
- hi_o  out  WIDTH  registered HI result (remainder for divides).
- lo_o  out  WIDTH  registered LO result (quotient for divides).

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: when start_i & ~flush_i, latch op_i, a_i, b_i, hi_i and lo_i. Ops 0,1,4-7 go to MUL. Ops 2,3 go to DIV, or straight to FIX if b_i == 0.
- Signed ops (0,2,4,6) take the magnitudes of the operands and record result signs. Product sign = sign(a) ^ sign(b). Quotient sign = sign(a) ^ sign(b). Remainder sign = sign(a).
- MUL: shift-add. Each cycle adds (multiplicand * next MUL_STEP multiplier bits) into a 2*WIDTH accumulator. Runs N = WIDTH/MUL_STEP cycles, then goes to FIX.
- DIV: restoring division, one quotient bit per cycle. Runs WIDTH cycles, then goes to FIX.
- FIX: apply the sign corrections. For ops 4/5, result = {hi,lo} + product. For ops 6/7, result = {hi,lo} - product. All arithmetic is modulo 2^(2*WIDTH). Write hi_o/lo_o, then go to DONE.
- Divide by zero: lo_o = all ones, hi_o = a_i (raw operand, both signednesses).
- Overflow case (DIV, most-negative / -1): lo_o = 100..0, hi_o = 0. No trap is raised.
- DONE: done_o = 1, then return to IDLE. start_i is ignored in DONE; the instruction leaves EXE at the end of this cycle.
- stall_o = (IDLE & start_i & ~flush_i) | MUL | DIV | FIX. It is low in DONE and in idle IDLE.
- flush_i in any state: go to IDLE on the next edge. done_o is not pulsed and hi_o/lo_o keep their prior values. Flush wins over a same-cycle start and over the FIX->DONE transition.
- hi_o/lo_o change only in FIX and hold until the next completed operation.

## Timing
- Reset: state = IDLE, stall_o = 0, done_o = 0, hi_o = 0, lo_o = 0, and all internal registers are cleared. A reset mid-operation discards the operation immediately.
- Cycle 0 is the IDLE cycle in which start is accepted; stall_o is already high in that cycle (combinational from start_i).
- Multiply/accumulate: MUL occupies cycles 1..N and FIX is cycle N+1. done_o is high in cycle N+2 (cycle 10 for the defaults).
- Divide: DIV occupies cycles 1..WIDTH and FIX is cycle WIDTH+1. done_o is high in cycle WIDTH+2 (cycle 34 for the defaults).
- Divide by zero: FIX is cycle 1 and done_o is high in cycle 2.
- stall_o is high from cycle 0 through the FIX cycle inclusive.
- Back-to-back: the next start can be accepted in the cycle after DONE.
- hi_o/lo_o are registered: they update on the edge ending FIX and are visible in the DONE cycle.

## Test plan
- MULT a=0xFFFFFFFE, b=0x3 -> done_o in cycle 10, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA; stall_o high in cycles 0-9, low in cycle 10.
- DIVU a=100, b=7 -> done_o in cycle 34, lo_o=14, hi_o=2. DIV a=-7, b=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- MADDU hi_i=0, lo_i=0xFFFFFFFF, a=1, b=1 -> hi_o=1, lo_o=0. MSUB hi_i=0, lo_i=0, a=1, b=1 -> hi_o=lo_o=0xFFFFFFFF.
- DIVU a=5, b=0 -> done_o in cycle 2, lo_o=0xFFFFFFFF, hi_o=5.
- Run MULTU 3*4 (hi_o=0, lo_o=12), then start DIV and assert flush_i in cycle 5:
  - state is IDLE next cycle, stall_o low, and no done_o pulse;
  - hi_o=0 and lo_o=12 are retained;
  - a new MULTU started in the next cycle completes normally.
- Assert rst asynchronously mid-DIV -> all outputs go to 0 immediately with no done_o pulse. Also regress WIDTH=16, MUL_STEP=2: MULTU 0xFFFF*0xFFFF -> hi_o=0xFFFE, lo_o=0x0001, done_o in cycle 10.
